// File: rtl/detector_jogada_pkg.sv
// -----------------------------------------------------------------------------
// detector_jogada_pkg
// Shared game package: FSM state encodings for the press detector, the
// default number of note buttons, and a lowest-set-bit helper.
// -----------------------------------------------------------------------------
package detector_jogada_pkg;

  // Default number of note buttons on the instrument.
  localparam int unsigned NUM_BOTOES_PADRAO = 7;

  // Press-detector states; the encoding is visible on db_estado.
  typedef enum logic [1:0] {
    SOLTO       = 2'd0,
    PRESSIONADO = 2'd1,
    SOLTANDO    = 2'd2
  } estado_t;

  // Index of the lowest set bit of an up-to-8-bit vector; 0 when empty.
  function automatic logic [2:0] indice_menor_bit(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    // Scan downwards so the lowest set bit wins.
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// -----------------------------------------------------------------------------
// sincronizador_2ff
// Two-flop synchronizer bringing an asynchronous vector into the clock domain.
// Ports:
//   i_clk   - destination clock
//   i_rst_n - asynchronous active-low reset (clears both stages)
//   i_d     - asynchronous input vector
//   o_q     - synchronized vector (second stage)
// -----------------------------------------------------------------------------
module sincronizador_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/detector_jogada.sv
// -----------------------------------------------------------------------------
// detector_jogada
// Debounces the raw note buttons and emits one registered pulse per accepted
// press, capturing the button combination pressed.
// Ports:
//   clock                 - system clock, rising edge
//   reset                 - asynchronous active-low reset
//   botoes                - raw asynchronous button levels
//   botoes_estaveis       - debounced button vector
//   tem_jogada            - one-cycle pulse per accepted press
//   tem_botao_pressionado - any debounced button high
//   botoes_jogada         - debounced vector captured at the press
//   codigo_botao          - index of lowest set bit of botoes_jogada
//   multiplos             - more than one bit set in botoes_jogada
//   db_estado             - current FSM state (debug)
// -----------------------------------------------------------------------------
module detector_jogada
  import detector_jogada_pkg::*;
#(
  parameter int unsigned NUM_BOTOES      = NUM_BOTOES_PADRAO,
  parameter int unsigned DEBOUNCE_CICLOS = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_BOTOES-1:0] botoes,
  output logic [NUM_BOTOES-1:0] botoes_estaveis,
  output logic                  tem_jogada,
  output logic                  tem_botao_pressionado,
  output logic [NUM_BOTOES-1:0] botoes_jogada,
  output logic [2:0]            codigo_botao,
  output logic                  multiplos,
  output logic [1:0]            db_estado
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CICLOS);
  localparam logic [CW-1:0] CONT_MAX = CW'(DEBOUNCE_CICLOS - 1);
  localparam logic [CW-1:0] CONT_UM  = CW'(1);
  localparam logic [NUM_BOTOES-1:0] VET_UM = NUM_BOTOES'(1);

  logic [NUM_BOTOES-1:0] w_s2;
  logic [NUM_BOTOES-1:0] r_candidato;
  logic [CW-1:0]         r_cont;
  logic [NUM_BOTOES-1:0] r_estaveis;
  logic [NUM_BOTOES-1:0] r_jogada;
  logic                  r_tem_jogada;
  estado_t               r_estado;

  sincronizador_2ff #(
    .WIDTH (NUM_BOTOES)
  ) u_sinc (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_d     (botoes),
    .o_q     (w_s2)
  );

  // Debounce: any change restarts the count; the candidate is accepted once
  // the count reaches its top, where it then saturates.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_candidato <= '0;
      r_cont      <= '0;
      r_estaveis  <= '0;
    end else if (w_s2 != r_candidato) begin
      r_candidato <= w_s2;
      r_cont      <= '0;
    end else if (r_cont == CONT_MAX) begin
      r_estaveis <= r_candidato;
    end else begin
      r_cont <= r_cont + CONT_UM;
    end
  end

  // Press FSM with registered pulse and capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado     <= SOLTO;
      r_tem_jogada <= 1'b0;
      r_jogada     <= '0;
    end else begin
      r_tem_jogada <= 1'b0;
      case (r_estado)
        SOLTO: begin
          if (r_estaveis != '0) begin
            r_estado     <= PRESSIONADO;
            r_tem_jogada <= 1'b1;
            r_jogada     <= r_estaveis;
          end
        end
        PRESSIONADO: begin
          if (r_estaveis == '0) r_estado <= SOLTANDO;
        end
        SOLTANDO: begin
          // A reappearing button returns to the held state without a new pulse.
          r_estado <= (r_estaveis == '0) ? SOLTO : PRESSIONADO;
        end
        default: r_estado <= SOLTO;
      endcase
    end
  end

  assign botoes_estaveis       = r_estaveis;
  assign tem_jogada            = r_tem_jogada;
  assign tem_botao_pressionado = (r_estaveis != '0);
  assign botoes_jogada         = r_jogada;
  assign codigo_botao          = indice_menor_bit(8'(r_jogada));
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multiplos             = ((r_jogada & (r_jogada - VET_UM)) != '0);
  assign db_estado             = r_estado;

endmodule
